// File: rtl/queen_pkg.sv
// Shared types and helpers for the N-Queens search controller.
package queen_pkg;

    localparam int unsigned RW_DFLT = 3;
    localparam int unsigned ABS_W   = 8;

    // Stack word layout: {row, col}
    localparam int unsigned ROW_LSB = RW_DFLT;
    localparam int unsigned COL_LSB = 0;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        TRY       = 4'd1,
        PUSH      = 4'd2,
        WAIT_PUSH = 4'd3,
        SOLN      = 4'd4,
        POP       = 4'd5,
        WAIT_POP  = 4'd6,
        DONE      = 4'd7,
        ERR       = 4'd8
    } state_e;

    function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
        return (a >= b) ? ABS_W'(a - b) : ABS_W'(b - a);
    endfunction

endpackage

// File: rtl/queen_conflict_check.sv
// Combinational test: is a queen at (row, col) free of column and diagonal
// conflicts with every queen already placed in rows 0..row-1?
module queen_conflict_check
    import queen_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned RW = RW_DFLT
) (
    input  logic [N*RW-1:0] board_i,
    input  logic [RW-1:0]   row_i,
    input  logic [RW-1:0]   col_i,
    output logic            safe_o
);

    // Differences are taken zero-extended so row - r never wraps for r < row.
    always_comb begin
        safe_o = 1'b1;
        for (int unsigned r = 0; r < N; r++) begin
            if (ABS_W'(r) < ABS_W'(row_i)) begin
                if (board_i[r*RW +: RW] == col_i) begin
                    safe_o = 1'b0;
                end
                if (abs_diff(ABS_W'(board_i[r*RW +: RW]), ABS_W'(col_i)) ==
                    ABS_W'(ABS_W'(row_i) - ABS_W'(r))) begin
                    safe_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/queen_backtrack_ctrl.sv
// Depth-first N-Queens search controller; keeps the placement path on an
// external stack and enumerates every solution.
module queen_backtrack_ctrl
    import queen_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned RW   = RW_DFLT,
    parameter int unsigned DW   = 2*RW,
    parameter int unsigned CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            stk_push,
    output logic            stk_pop,
    output logic [DW-1:0]   stk_din,
    input  logic [DW-1:0]   stk_dout,
    input  logic            stk_ready,
    input  logic            stk_overflow,
    input  logic            stk_underflow,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic            sol_valid,
    output logic [N*RW-1:0] sol_board,
    output logic [CNTW-1:0] sol_count
);

    localparam int unsigned CW       = RW + 1;
    localparam logic [CW-1:0] COL_END  = CW'(N);
    localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
    localparam logic [1:0]    HS_SKIP  = 2'd2;

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [N*RW-1:0]   board_q, board_d;
    logic [1:0]        hs_wait_q, hs_wait_d;
    logic              push_q, push_d;
    logic              pop_q, pop_d;
    logic [DW-1:0]     din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              sol_valid_q, sol_valid_d;
    logic [N*RW-1:0]   sol_board_q, sol_board_d;
    logic [CNTW-1:0]   sol_count_q, sol_count_d;
    logic              safe_c;

    queen_conflict_check #(
        .N  (N),
        .RW (RW)
    ) u_conflict (
        .board_i (board_q),
        .row_i   (row_q),
        .col_i   (col_q[RW-1:0]),
        .safe_o  (safe_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            board_q     <= '0;
            hs_wait_q   <= '0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            din_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            sol_valid_q <= 1'b0;
            sol_board_q <= '0;
            sol_count_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            board_q     <= board_d;
            hs_wait_q   <= hs_wait_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            sol_valid_q <= sol_valid_d;
            sol_board_q <= sol_board_d;
            sol_count_q <= sol_count_d;
        end
    end

    // A request is visible the cycle after it is decided; that cycle and the
    // next are skipped before stk_ready is trusted again.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        board_d     = board_q;
        hs_wait_d   = hs_wait_q;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        din_d       = din_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        sol_valid_d = 1'b0;
        sol_board_d = sol_board_q;
        sol_count_d = sol_count_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    sol_count_d = '0;
                    row_d       = '0;
                    col_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = TRY;
                end
            end
            TRY: begin
                if (col_q == COL_END) begin
                    state_d = (row_q == '0) ? DONE : POP;
                end else if (safe_c) begin
                    board_d[row_q*RW +: RW] = col_q[RW-1:0];
                    din_d   = DW'({row_q, col_q[RW-1:0]});
                    state_d = PUSH;
                end else begin
                    col_d = CW'(col_q + 1'b1);
                end
            end
            PUSH: begin
                if (stk_ready) begin
                    push_d    = 1'b1;
                    hs_wait_d = HS_SKIP;
                    state_d   = WAIT_PUSH;
                end
            end
            WAIT_PUSH: begin
                if (hs_wait_q != '0) begin
                    hs_wait_d = 2'(hs_wait_q - 2'd1);
                end else if (stk_ready) begin
                    if (stk_overflow) begin
                        state_d = ERR;
                    end else if (row_q == ROW_LAST) begin
                        state_d = SOLN;
                    end else begin
                        row_d   = RW'(row_q + 1'b1);
                        col_d   = '0;
                        state_d = TRY;
                    end
                end
            end
            SOLN: begin
                sol_valid_d = 1'b1;
                sol_board_d = board_q;
                if (sol_count_q != '1) begin
                    sol_count_d = CNTW'(sol_count_q + 1'b1);
                end
                state_d = POP;
            end
            POP: begin
                if (stk_ready) begin
                    pop_d     = 1'b1;
                    hs_wait_d = HS_SKIP;
                    state_d   = WAIT_POP;
                end
            end
            WAIT_POP: begin
                if (hs_wait_q != '0) begin
                    hs_wait_d = 2'(hs_wait_q - 2'd1);
                end else if (stk_ready) begin
                    if (stk_underflow) begin
                        state_d = ERR;
                    end else begin
                        // Resume just past the column of the popped queen.
                        row_d   = stk_dout[ROW_LSB +: RW];
                        col_d   = CW'(CW'(stk_dout[COL_LSB +: RW]) + 1'b1);
                        state_d = TRY;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERR: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stk_push  = push_q;
    assign stk_pop   = pop_q;
    assign stk_din   = din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign sol_valid = sol_valid_q;
    assign sol_board = sol_board_q;
    assign sol_count = sol_count_q;

endmodule
